// File: rtl/dma_dccm_responder.sv
// DMA-to-DCCM responder: queues DMA requests, checks range/alignment, yields to
// core LSU traffic, performs one SRAM access per request and returns one response.
module dma_dccm_responder #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] DCCM_BASE = 32'hF004_0000,
   parameter int unsigned DCCM_AW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dma_dccm_req,
   output logic                 dma_dccm_req_ready,
   input  logic                 dma_req_write,
   input  logic [31:0]          dma_req_addr,
   input  logic [1:0]           dma_req_sz,
   input  logic [31:0]          dma_req_wdata,
   output logic                 dma_dccm_resp_valid,
   input  logic                 dma_resp_ready,
   output logic [31:0]          dma_resp_rdata,
   output logic                 dma_resp_error,
   output logic                 dma_resp_write,
   input  logic                 lsu_dccm_busy,
   input  logic                 freeze,
   output logic                 dccm_rden,
   output logic                 dccm_wren,
   output logic [DCCM_AW-3:0]   dccm_addr,
   output logic [31:0]          dccm_wr_data,
   output logic [3:0]           dccm_wr_be,
   input  logic [31:0]          dccm_rd_data,
   output logic                 dma_idle
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StRdWait,
      StResp
   } state_e;

   // Request FIFO storage and pointers
   logic          wr_mem_q    [DEPTH];
   logic          wr_mem_d    [DEPTH];
   logic [31:0]   addr_mem_q  [DEPTH];
   logic [31:0]   addr_mem_d  [DEPTH];
   logic [1:0]    sz_mem_q    [DEPTH];
   logic [1:0]    sz_mem_d    [DEPTH];
   logic [31:0]   wdata_mem_q [DEPTH];
   logic [31:0]   wdata_mem_d [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;

   // FSM and response registers
   state_e        state_q, state_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          error_q, error_d;
   logic          write_q, write_d;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          start_rd;
   logic          start_wr;

   logic          head_write;
   logic [31:0]   head_addr;
   logic [1:0]    head_sz;
   logic [31:0]   head_wdata;
   logic          head_err;
   logic [3:0]    head_be;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);
   // Ready looks only at occupancy so a full FIFO refuses even while popping
   assign push  = dma_dccm_req & ~full;

   assign head_write = wr_mem_q[rd_ptr_q];
   assign head_addr  = addr_mem_q[rd_ptr_q];
   assign head_sz    = sz_mem_q[rd_ptr_q];
   assign head_wdata = wdata_mem_q[rd_ptr_q];

   // Range and alignment check on the FIFO head
   always_comb begin
      head_err = 1'b0;
      if (head_addr[31:DCCM_AW] != DCCM_BASE[31:DCCM_AW]) begin
         head_err = 1'b1;
      end
      unique case (head_sz)
         2'd0: ;
         2'd1: if (head_addr[0] != 1'b0) head_err = 1'b1;
         2'd2: if (head_addr[1:0] != 2'b00) head_err = 1'b1;
         default: head_err = 1'b1;
      endcase
   end

   // Byte-enable generation from size and low address bits
   always_comb begin
      head_be = 4'b0000;
      unique case (head_sz)
         2'd0: head_be = 4'b0001 << head_addr[1:0];
         2'd1: head_be = 4'b0011 << head_addr[1:0];
         2'd2: head_be = 4'b1111;
         default: head_be = 4'b0000;
      endcase
   end

   // FIFO next-state: storage write on push, pointer and occupancy update
   always_comb begin
      wr_mem_d    = wr_mem_q;
      addr_mem_d  = addr_mem_q;
      sz_mem_d    = sz_mem_q;
      wdata_mem_d = wdata_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) begin
         wr_mem_d[wr_ptr_q]    = dma_req_write;
         addr_mem_d[wr_ptr_q]  = dma_req_addr;
         sz_mem_d[wr_ptr_q]    = dma_req_sz;
         wdata_mem_d[wr_ptr_q] = dma_req_wdata;
         wr_ptr_d              = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PtrW + 1)'(1);
         2'b01:   count_d = count_q - (PtrW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            wr_mem_q[i]    <= 1'b0;
            addr_mem_q[i]  <= 32'h0;
            sz_mem_q[i]    <= 2'd0;
            wdata_mem_q[i] <= 32'h0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_mem_q    <= wr_mem_d;
         addr_mem_q  <= addr_mem_d;
         sz_mem_q    <= sz_mem_d;
         wdata_mem_q <= wdata_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // FSM next-state, SRAM strobes and response register updates
   always_comb begin
      state_d  = state_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      write_d  = write_q;
      start_rd = 1'b0;
      start_wr = 1'b0;
      pop      = 1'b0;
      unique case (state_q)
         StIdle: begin
            // freeze only blocks starting; the FIFO still fills
            if (!empty && !freeze) begin
               if (head_err) begin
                  error_d = 1'b1;
                  write_d = head_write;
                  rdata_d = 32'h0;
                  state_d = StResp;
               end else if (!lsu_dccm_busy) begin
                  error_d = 1'b0;
                  rdata_d = 32'h0;
                  if (head_write) begin
                     start_wr = 1'b1;
                     write_d  = 1'b1;
                     state_d  = StResp;
                  end else begin
                     start_rd = 1'b1;
                     write_d  = 1'b0;
                     state_d  = StRdWait;
                  end
               end
            end
         end
         StRdWait: begin
            // SRAM data is valid the cycle after the read strobe
            rdata_d = dccm_rd_data;
            state_d = StResp;
         end
         StResp: begin
            if (dma_resp_ready) begin
               pop     = 1'b1;
               rdata_d = 32'h0;
               error_d = 1'b0;
               write_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         rdata_q <= 32'h0;
         error_q <= 1'b0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         write_q <= write_d;
      end
   end

   assign dma_dccm_req_ready  = ~full;
   assign dma_dccm_resp_valid = (state_q == StResp);
   assign dma_resp_rdata      = rdata_q;
   assign dma_resp_error      = error_q;
   assign dma_resp_write      = write_q;
   assign dma_idle            = empty & (state_q == StIdle);

   // SRAM side is held at zero whenever no access is being started
   assign dccm_rden    = start_rd;
   assign dccm_wren    = start_wr;
   assign dccm_addr    = (start_rd | start_wr) ? head_addr[DCCM_AW-1:2] : '0;
   assign dccm_wr_data = start_wr ? head_wdata : 32'h0;
   assign dccm_wr_be   = start_wr ? head_be : 4'b0000;

endmodule

// File: tb/tb_dma_dccm_responder.sv
// Self-checking bench for dma_dccm_responder with an SRAM model and response scoreboard.
module tb_dma_dccm_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        dma_dccm_req;
   logic        dma_dccm_req_ready;
   logic        dma_req_write;
   logic [31:0] dma_req_addr;
   logic [1:0]  dma_req_sz;
   logic [31:0] dma_req_wdata;
   logic        dma_dccm_resp_valid;
   logic        dma_resp_ready;
   logic [31:0] dma_resp_rdata;
   logic        dma_resp_error;
   logic        dma_resp_write;
   logic        lsu_dccm_busy;
   logic        freeze;
   logic        dccm_rden;
   logic        dccm_wren;
   logic [13:0] dccm_addr;
   logic [31:0] dccm_wr_data;
   logic [3:0]  dccm_wr_be;
   logic [31:0] dccm_rd_data;
   logic        dma_idle;

   typedef struct packed {
      logic        write;
      logic        error;
      logic [31:0] rdata;
   } resp_t;

   resp_t       sb[$];
   logic [31:0] mem [0:16383];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   dma_dccm_responder #(
      .DEPTH     (2),
      .DCCM_BASE (32'hF004_0000),
      .DCCM_AW   (16)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .dma_dccm_req        (dma_dccm_req),
      .dma_dccm_req_ready  (dma_dccm_req_ready),
      .dma_req_write       (dma_req_write),
      .dma_req_addr        (dma_req_addr),
      .dma_req_sz          (dma_req_sz),
      .dma_req_wdata       (dma_req_wdata),
      .dma_dccm_resp_valid (dma_dccm_resp_valid),
      .dma_resp_ready      (dma_resp_ready),
      .dma_resp_rdata      (dma_resp_rdata),
      .dma_resp_error      (dma_resp_error),
      .dma_resp_write      (dma_resp_write),
      .lsu_dccm_busy       (lsu_dccm_busy),
      .freeze              (freeze),
      .dccm_rden           (dccm_rden),
      .dccm_wren           (dccm_wren),
      .dccm_addr           (dccm_addr),
      .dccm_wr_data        (dccm_wr_data),
      .dccm_wr_be          (dccm_wr_be),
      .dccm_rd_data        (dccm_rd_data),
      .dma_idle            (dma_idle)
   );

   // SRAM model: registered read data, byte-enabled writes
   always @(posedge clk) begin
      if (dccm_rden) dccm_rd_data <= mem[dccm_addr];
      if (dccm_wren) begin
         for (int b = 0; b < 4; b++) begin
            if (dccm_wr_be[b]) mem[dccm_addr][b*8 +: 8] <= dccm_wr_data[b*8 +: 8];
         end
      end
   end

   // Response monitor: each accepted response is compared against the scoreboard head
   always @(negedge clk) begin
      resp_t exp_r;
      if (!rst && dma_dccm_resp_valid && dma_resp_ready) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_resp: got write=%0b error=%0b rdata=%h, expected none",
                     dma_resp_write, dma_resp_error, dma_resp_rdata);
         end else begin
            exp_r = sb.pop_front();
            if ({dma_resp_write, dma_resp_error, dma_resp_rdata} !== exp_r) begin
               fails++;
               $display("FAIL resp_data: got write=%0b error=%0b rdata=%h, expected write=%0b error=%0b rdata=%h",
                        dma_resp_write, dma_resp_error, dma_resp_rdata,
                        exp_r.write, exp_r.error, exp_r.rdata);
            end
         end
      end
   end

   // Drive one request and record its expected response once accepted
   task automatic push(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                       input logic [31:0] wdata);
      resp_t e;
      logic  err;
      int    n;
      err = (addr[31:16] != 16'hF004) || (sz == 2'd3) || (sz == 2'd1 && addr[0]) ||
            (sz == 2'd2 && addr[1:0] != 2'b00);
      e.write = wr;
      e.error = err;
      e.rdata = (wr || err) ? 32'h0 : mem[addr[15:2]];
      @(negedge clk);
      dma_req_write = wr;
      dma_req_addr  = addr;
      dma_req_sz    = sz;
      dma_req_wdata = wdata;
      dma_dccm_req  = 1'b1;
      n = 0;
      while (!dma_dccm_req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!dma_dccm_req_ready) begin
         tests++;
         fails++;
         $display("FAIL push_accept: got ready=0, expected ready=1 within 100 cycles");
         dma_dccm_req = 1'b0;
         return;
      end
      sb.push_back(e);
      @(posedge clk);
      #1 dma_dccm_req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !dma_idle) && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sb.size() != 0 || !dma_idle) begin
         fails++;
         $display("FAIL drain: got pending=%0d idle=%0b, expected pending=0 idle=1",
                  sb.size(), dma_idle);
      end
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      dma_dccm_req   = 1'b0;
      dma_req_write  = 1'b0;
      dma_req_addr   = 32'h0;
      dma_req_sz     = 2'd0;
      dma_req_wdata  = 32'h0;
      dma_resp_ready = 1'b1;
      lsu_dccm_busy  = 1'b0;
      freeze         = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({dma_dccm_req_ready, dma_idle, dma_dccm_resp_valid, dccm_rden, dccm_wren,
           dma_resp_error, dma_resp_write} !== 7'b1100000 ||
          dma_resp_rdata !== 32'h0 || dccm_addr !== 14'h0 || dccm_wr_data !== 32'h0 ||
          dccm_wr_be !== 4'h0) begin
         fails++;
         $display("FAIL reset_outputs: got rdy=%0b idle=%0b vld=%0b rden=%0b wren=%0b err=%0b wr=%0b rdata=%h, expected 1 1 0 0 0 0 0 0",
                  dma_dccm_req_ready, dma_idle, dma_dccm_resp_valid, dccm_rden, dccm_wren,
                  dma_resp_error, dma_resp_write, dma_resp_rdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_read();
      push(1'b0, 32'hF004_0044, 2'd2, 32'h0);
      @(negedge clk);
      tests++;
      if (dccm_rden !== 1'b1 || dccm_wren !== 1'b0 || dccm_addr !== 14'h11) begin
         fails++;
         $display("FAIL read_strobe: got rden=%0b wren=%0b addr=%h, expected 1 0 0011",
                  dccm_rden, dccm_wren, dccm_addr);
      end
      @(negedge clk);
      tests++;
      if (dma_dccm_resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL read_lat2: got valid=%0b, expected 0", dma_dccm_resp_valid);
      end
      @(negedge clk);
      tests++;
      if (dma_dccm_resp_valid !== 1'b1) begin
         fails++;
         $display("FAIL read_lat3: got valid=%0b, expected 1", dma_dccm_resp_valid);
      end
      drain();
   endtask

   task automatic test_write();
      push(1'b1, 32'hF004_0007, 2'd0, 32'hAB00_0000);
      @(negedge clk);
      tests++;
      if (dccm_wren !== 1'b1 || dccm_rden !== 1'b0 || dccm_wr_be !== 4'b1000 ||
          dccm_addr !== 14'h1 || dccm_wr_data !== 32'hAB00_0000) begin
         fails++;
         $display("FAIL write_strobe: got wren=%0b rden=%0b be=%b addr=%h wdata=%h, expected 1 0 1000 0001 ab000000",
                  dccm_wren, dccm_rden, dccm_wr_be, dccm_addr, dccm_wr_data);
      end
      @(negedge clk);
      tests++;
      if (dma_dccm_resp_valid !== 1'b1) begin
         fails++;
         $display("FAIL write_lat2: got valid=%0b, expected 1", dma_dccm_resp_valid);
      end
      drain();
      tests++;
      if (mem[1] !== 32'hAB00_0000) begin
         fails++;
         $display("FAIL write_mem: got %h, expected ab000000", mem[1]);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3];
      logic [1:0]  szs   [3];
      addrs[0] = 32'hF005_0000; szs[0] = 2'd2;
      addrs[1] = 32'hF004_0001; szs[1] = 2'd1;
      addrs[2] = 32'hF004_0000; szs[2] = 2'd3;
      for (int i = 0; i < 3; i++) begin
         push(1'b0, addrs[i], szs[i], 32'h0);
         @(negedge clk);
         tests++;
         if (dccm_rden !== 1'b0 || dccm_wren !== 1'b0) begin
            fails++;
            $display("FAIL err_nostrobe[%0d]: got rden=%0b wren=%0b, expected 0 0",
                     i, dccm_rden, dccm_wren);
         end
         @(negedge clk);
         tests++;
         if (dma_dccm_resp_valid !== 1'b1 || dma_resp_error !== 1'b1) begin
            fails++;
            $display("FAIL err_lat2[%0d]: got valid=%0b error=%0b, expected 1 1",
                     i, dma_dccm_resp_valid, dma_resp_error);
         end
         drain();
      end
   endtask

   task automatic test_lsu_priority();
      lsu_dccm_busy = 1'b1;
      push(1'b0, 32'hF004_0080, 2'd2, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (dccm_rden !== 1'b0 || dccm_wren !== 1'b0) begin
            fails++;
            $display("FAIL lsu_block[%0d]: got rden=%0b wren=%0b, expected 0 0",
                     i, dccm_rden, dccm_wren);
         end
      end
      lsu_dccm_busy = 1'b0;
      #1;
      tests++;
      if (dccm_rden !== 1'b1 || dccm_addr !== 14'h20) begin
         fails++;
         $display("FAIL lsu_release: got rden=%0b addr=%h, expected 1 0020", dccm_rden, dccm_addr);
      end
      drain();
   endtask

   task automatic test_freeze();
      push(1'b0, 32'hF004_00C0, 2'd2, 32'h0);
      @(negedge clk);
      tests++;
      if (dccm_rden !== 1'b1) begin
         fails++;
         $display("FAIL freeze_first_rd: got rden=%0b, expected 1", dccm_rden);
      end
      @(posedge clk);
      #1 freeze = 1'b1;
      push(1'b0, 32'hF004_00C4, 2'd2, 32'h0);
      @(negedge clk);
      tests++;
      if (dma_dccm_resp_valid !== 1'b1 || dma_idle !== 1'b0) begin
         fails++;
         $display("FAIL freeze_rdwait_done: got valid=%0b idle=%0b, expected 1 0",
                  dma_dccm_resp_valid, dma_idle);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (dccm_rden !== 1'b0 || dccm_wren !== 1'b0 || dma_idle !== 1'b0) begin
            fails++;
            $display("FAIL freeze_hold[%0d]: got rden=%0b wren=%0b idle=%0b, expected 0 0 0",
                     i, dccm_rden, dccm_wren, dma_idle);
         end
      end
      freeze = 1'b0;
      #1;
      tests++;
      if (dccm_rden !== 1'b1 || dccm_addr !== 14'h31) begin
         fails++;
         $display("FAIL freeze_release: got rden=%0b addr=%h, expected 1 0031", dccm_rden, dccm_addr);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      dma_resp_ready = 1'b0;
      push(1'b1, 32'hF004_0108, 2'd1, 32'h0000_1234);
      push(1'b0, 32'hF004_0100, 2'd2, 32'h0);
      fork
         push(1'b0, 32'hF004_0104, 2'd2, 32'h0);
         begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               tests++;
               if (dma_dccm_req_ready !== 1'b0) begin
                  fails++;
                  $display("FAIL bp_full[%0d]: got ready=%0b, expected 0", i, dma_dccm_req_ready);
               end
            end
            dma_resp_ready = 1'b1;
         end
      join
      drain();
      tests++;
      if (mem[32'h42] !== 32'hFFFF_1234) begin
         fails++;
         $display("FAIL bp_write_mem: got %h, expected ffff1234", mem[32'h42]);
      end
   endtask

   task automatic test_reset_mid_read();
      push(1'b0, 32'hF004_0140, 2'd2, 32'h0);
      @(negedge clk);
      tests++;
      if (dccm_rden !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre_rd: got rden=%0b, expected 1", dccm_rden);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({dccm_rden, dccm_wren, dma_dccm_resp_valid, dma_idle, dma_dccm_req_ready} !== 5'b00011) begin
         fails++;
         $display("FAIL rst_async: got rden=%0b wren=%0b valid=%0b idle=%0b ready=%0b, expected 0 0 0 1 1",
                  dccm_rden, dccm_wren, dma_dccm_resp_valid, dma_idle, dma_dccm_req_ready);
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tests++;
         if (dma_dccm_resp_valid !== 1'b0 || dma_idle !== 1'b1) begin
            fails++;
            $display("FAIL rst_no_resp[%0d]: got valid=%0b idle=%0b, expected 0 1",
                     i, dma_dccm_resp_valid, dma_idle);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      mem[32'h11] = 32'hCAFE_F00D;
      mem[32'h20] = 32'h1234_5678;
      mem[32'h30] = 32'hA5A5_0001;
      mem[32'h31] = 32'h5A5A_0002;
      mem[32'h40] = 32'h0BAD_BEEF;
      mem[32'h41] = 32'h00C0_FFEE;
      mem[32'h42] = 32'hFFFF_FFFF;
      mem[32'h50] = 32'h7777_8888;
      dccm_rd_data = 32'h0;
      test_reset();
      test_read();
      test_write();
      test_errors();
      test_lsu_priority();
      test_freeze();
      test_back_to_back();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dma_dccm_responder.md
Name: dma_dccm_responder

Overview:
- DCCM-side responder for DMA memory requests targeting the data closely-coupled memory.
- Sits between the DMA slave port and the DCCM SRAM macro.
- Accepts requests into a small FIFO and checks range and alignment.
- Arbitrates behind core LSU traffic, performs one SRAM access per request, and returns one response per request with a ready/valid handshake.
- Honours the core freeze signal by not starting new SRAM accesses.

Parameters:
- DEPTH, 2: request FIFO entries; power of 2, at least 2.
- DCCM_BASE, 32'hF004_0000: DCCM byte base address; aligned to the DCCM size.
- DCCM_AW, 16: log2 of DCCM size in bytes.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dma_dccm_req  in  1  request valid.
- dma_dccm_req_ready  out  1  FIFO can accept a request.
- dma_req_write  in  1  1 = write, 0 = read.
- dma_req_addr  in  32  byte address.
- dma_req_sz  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- dma_req_wdata  in  32  write data, already lane-aligned.
- dma_dccm_resp_valid  out  1  response valid.
- dma_resp_ready  in  1  response accepted.
- dma_resp_rdata  out  32  read word, full 32-bit line, unshifted; 0 for writes and errors.
- dma_resp_error  out  1  range or alignment error.
- dma_resp_write  out  1  echoes the request type.
- lsu_dccm_busy  in  1  core owns the DCCM this cycle; the core has priority.
- freeze  in  1  no new SRAM access may start.
- dccm_rden  out  1  SRAM read strobe.
- dccm_wren  out  1  SRAM write strobe.
- dccm_addr  out  DCCM_AW-2  SRAM word index, addr[DCCM_AW-1:2].
- dccm_wr_data  out  32  SRAM write data.
- dccm_wr_be  out  4  SRAM byte enables.
- dccm_rd_data  in  32  SRAM read data, valid the cycle after dccm_rden.
- dma_idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset, asserted at any time:
  - FIFO emptied, FSM to IDLE, in-flight request dropped.
  - All outputs 0 except dma_dccm_req_ready = 1 and dma_idle = 1.
  - SRAM strobes fall asynchronously.
- Enqueue:
  - Push on dma_dccm_req & dma_dccm_req_ready.
  - dma_dccm_req_ready = !full; it never depends on the pop in the same cycle, so a full FIFO refuses even while popping.
  - Push and pop may coincide when not full; occupancy is unchanged.
- Error check on the FIFO head, combinational:
  - error if addr[31:DCCM_AW] != DCCM_BASE[31:DCCM_AW];
  - or sz == 3;
  - or sz == 1 with addr[0] != 0;
  - or sz == 2 with addr[1:0] != 0.
- Byte enables:
  - sz 0: 4'b0001 << addr[1:0];
  - sz 1: 4'b0011 << addr[1:0];
  - sz 2: 4'b1111.
- FSM states: IDLE, RDWAIT, RESP.
- IDLE, with FIFO non-empty and !freeze:
  - error: go to RESP with error = 1, no SRAM access;
  - else if lsu_dccm_busy: stay in IDLE, strobes low;
  - else read: dccm_rden = 1 (combinational) this cycle, go to RDWAIT;
  - else write: dccm_wren = 1, dccm_wr_data and dccm_wr_be driven this cycle, go to RESP.
- freeze:
  - Only gates starting a new access from IDLE.
  - Does not affect RDWAIT or RESP, which always complete.
  - The FIFO keeps accepting requests.
- RDWAIT: capture dccm_rd_data into the response register, go to RESP. lsu_dccm_busy is ignored here.
- RESP:
  - dma_dccm_resp_valid = 1; rdata, error and write held stable.
  - On dma_resp_ready: pop the FIFO, clear valid, go to IDLE.
  - Holds indefinitely without ready.
- Latency, request handshake on edge E0, no stalls:
  - SRAM strobe in the cycle after E0;
  - read: resp_valid 3 cycles after E0;
  - write: resp_valid 2 cycles after E0;
  - error: resp_valid 2 cycles after E0.
- Ordering and throughput: responses in request order; at most one request in service; a new access starts no earlier than the cycle after the response handshake.
- dma_idle = FIFO empty & state == IDLE.

Test Plan:
- Read: preload word 0x11 with 0xCAFEF00D; read addr 0xF004_0044, sz 2 -> dccm_rden with dccm_addr 0x11 one cycle after E0; resp_valid 3 cycles after E0 with rdata 0xCAFEF00D, error 0.
- Write: byte write to 0xF004_0007, wdata 0xAB000000 -> dccm_wren with be 4'b1000 and addr 1; resp_valid 2 cycles after E0 with write 1, error 0.
- Errors:
  - addr 0xF005_0000 -> error response, no strobe;
  - sz 1 at addr ...01 -> error;
  - sz 3 -> error.
- LSU priority: lsu_dccm_busy held high for 5 cycles while a read is pending -> no strobe during those cycles; strobe in the first cycle busy is low; data correct.
- Freeze:
  - freeze asserted during RDWAIT -> response still completes;
  - a second queued request starts only after freeze deasserts;
  - dma_idle = 0 throughout.
- Backpressure: hold dma_resp_ready low and push 3 requests with DEPTH 2 -> ready deasserts after 2 accepts (one in RESP plus one queued); release ready -> responses in order.
- Reset mid-read in RDWAIT -> strobes and resp_valid go to 0 immediately; dma_idle = 1; no response is emitted after release.
